// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory path: access-size encoding, controller
// state type and a size legality helper.
package data_mem_ctrl_pkg;

  localparam int unsigned MEM_SIZE_W = 3;

  // Load/store access size as issued by the core's memory stage.
  typedef enum logic [MEM_SIZE_W-1:0] {
    BYTE_S = 3'd0,
    HALF_S = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd3,
    HALF_U = 3'd4
  } MEM_RW_SIZE;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } dmem_state_t;

  // Encodings above HALF_U have no meaning.
  function automatic logic size_legal(input logic [MEM_SIZE_W-1:0] size);
    return size <= HALF_U;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte/half lane handling: merges store data into a RAM word and extracts
// sign- or zero-extended load data from a RAM word. Purely combinational.
module dmem_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0]           word,
  input  logic [1:0]            off,
  input  logic [31:0]           wdata,
  input  logic [MEM_SIZE_W-1:0] size,
  output logic [31:0]           merged,
  output logic [31:0]           rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store merge: replace only the addressed lane; word stores take wdata whole.
  always_comb begin
    merged = word;
    case (size)
      BYTE_S, BYTE_U: merged[{off, 3'b000} +: 8]        = wdata[7:0];
      HALF_S, HALF_U: merged[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default:        merged                            = wdata;
    endcase
  end

  // Load extraction: pick lane, then extend according to signedness.
  always_comb begin
    byte_sel = 8'(word >> {off, 3'b000});
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE_S:  rdata = {{24{byte_sel[7]}}, byte_sel};
      BYTE_U:  rdata = {24'h000000, byte_sel};
      HALF_S:  rdata = {{16{half_sel[15]}}, half_sel};
      HALF_U:  rdata = {16'h0000, half_sel};
      WORD:    rdata = word;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: one request at a time over valid/ready, owns a
// word-wide synchronous RAM, sub-word stores via read-modify-write.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses
// into error responses; without it the low address bits are ignored.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [MEM_SIZE_W-1:0] req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t           state_q, state_d;
  logic                  we_q;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            off_q;
  logic [MEM_SIZE_W-1:0] size_q;
  logic [31:0]           wdata_q;
  logic                  err_q;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [31:0]           ram_q;
  logic [31:0]           merged;
  logic [31:0]           ext;
  logic                  accept;
  logic                  misalign;
  logic                  req_err;

  assign accept = req_valid & req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((req_size == HALF_S || req_size == HALF_U) && req_addr[0]) ||
                    (req_size == WORD && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Any address bit above the word-index field means the word is out of range.
  assign req_err = !size_legal(req_size) || ((req_addr >> (IDX_W + 2)) != '0) || misalign;

  // Next-state: errors skip the RAM; sub-word stores read before writing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)              state_d = StResp;
          else if (!req_we)         state_d = StRd;
          else if (req_size == WORD) state_d = StWr;
          else                      state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= '0;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[IDX_W+1:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
    end
  end

  // RAM: write at the edge ending WR, read word captured at the edge ending RD.
  always_ff @(posedge clk) begin
    if (state_q == StWr && !rst) begin
      mem[idx_q] <= merged;
    end
    if (state_q == StRd) begin
      ram_q <= mem[idx_q];
    end
  end

  dmem_lane_unit u_lane (
    .word   (ram_q),
    .off    (off_q),
    .wdata  (wdata_q),
    .size   (size_q),
    .merged (merged),
    .rdata  (ext)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid & err_q;
  // ram_q and the latched request are frozen in RESP, so data is stable under stall.
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DEPTH_WORDS (1024),
    .ADDR_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Issue one request from IDLE, return response and latency (edges after accept
  // at which rsp_valid is first seen; 1 = next edge).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL word_store_lat got=%0d want=2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL word_store_err got=%b want=0", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL word_store_rdata got=%h want=0", rd); end
    do_req(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL word_load_lat got=%0d want=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_data got=%h want=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL word_load_err got=%b want=0", er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h12, 3'd0, 32'h123456AA, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL byte_store_lat got=%0d want=3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL byte_store_err got=%b want=0", er); end
    do_req(1'b0, 32'h12, 3'd0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL byte_s_load got=%h want=ffffffaa", rd); end
    do_req(1'b0, 32'h12, 3'd3, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL byte_u_load got=%h want=000000aa", rd); end
    do_req(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAABEEF) begin bad++; $display("FAIL byte_merge_word got=%h want=deaabeef", rd); end
    do_req(1'b0, 32'h13, 3'd3, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL byte_u_lane3 got=%h want=000000de", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h14, 3'd2, 32'h0000_0000, rd, er, lat);
    do_req(1'b1, 32'h16, 3'd1, 32'h77778001, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL half_store_lat got=%0d want=3", lat); end
    do_req(1'b0, 32'h16, 3'd1, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL half_s_load got=%h want=ffff8001", rd); end
    do_req(1'b0, 32'h16, 3'd4, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL half_u_load got=%h want=00008001", rd); end
    do_req(1'b0, 32'h14, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h80010000) begin bad++; $display("FAIL half_merge_word got=%h want=80010000", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h10, 3'd6, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_size_err got=%b want=1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_size_rdata got=%h want=0", rd); end
    total++; if (lat !== 1) begin bad++; $display("FAIL err_size_lat got=%0d want=1", lat); end
    do_req(1'b0, 32'h1000, 3'd2, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_range_err got=%b want=1", er); end
    total++; if (lat !== 1) begin bad++; $display("FAIL err_range_lat got=%0d want=1", lat); end
    // Out-of-range store must not alias onto word 0.
    do_req(1'b1, 32'h0, 3'd2, 32'h01020304, rd, er, lat);
    do_req(1'b1, 32'h1000, 3'd2, 32'hBADBAD00, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_range_store got=%b want=1", er); end
    do_req(1'b0, 32'h0, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL err_no_write got=%h want=01020304", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b1, 32'h21, 3'd2, 32'h11223344, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", er); end
    do_req(1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL misalign_keep got=%h want=cafef00d", rd); end
`else
    total++; if (er !== 1'b0) begin bad++; $display("FAIL misalign_err got=%b want=0", er); end
    do_req(1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL misalign_write got=%h want=11223344", rd); end
`endif
  endtask

  task automatic test_stall_reset();
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'd2; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_rsp_timeout got=%b want=1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, rsp_valid); end
      total++; if (rsp_rdata !== 32'hDEAABEEF) begin bad++; $display("FAIL stall_data[%0d] got=%h want=deaabeef", i, rsp_rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    // Sub-word store, reset while in RD.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h11; req_size = 3'd3; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b want=0", req_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAABEEF) begin bad++; $display("FAIL rst_no_write got=%h want=deaabeef", rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 3'd0;
    req_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_misalign();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the RISC core's load/store path: the memory-side end of the core's `MEM_RW_SIZE`-qualified access interface. It accepts one request at a time over a valid/ready handshake and owns a word-wide synchronous RAM. Loads are returned sign- or zero-extended. Sub-word stores are done by read-modify-write. It sits between the core's memory stage and the data RAM and replaces direct RAM wiring.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_size`  in  3  `MEM_RW_SIZE` encoding: 0 BYTE_S, 1 HALF_S, 2 WORD, 3 BYTE_U, 4 HALF_U; 5–7 are illegal.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request was illegal; no RAM write took place.

## Operation
- States: IDLE, RD, WR, RESP.
- `req_ready` = 1 only in IDLE.
- Accept: `req_valid & req_ready` at an edge. Latch we, addr, size and wdata.
- Transitions from IDLE on accept:
  - Error → RESP with err = 1.
  - Load → RD → RESP.
  - Word store → WR → RESP.
  - Byte/half store → RD → WR → RESP.
- RD: presents word index `addr[log2(DEPTH_WORDS)+1:2]` to the RAM. The read word is latched at the end of RD.
- WR: writes one full word.
  - Word store: the write value is `wdata`.
  - Byte store: `wdata[7:0]` is merged into lane `addr[1:0]` of the latched word.
  - Half store: `wdata[15:0]` is merged into half `addr[1]` of the latched word.
  - Signed and unsigned sizes behave identically for stores.
- RESP: `rsp_valid` = 1 and is held, with data stable, until `rsp_ready`. On `rsp_ready` go to IDLE. A new request is accepted no earlier than the next edge; there is no overlap.
- Load extraction: select the byte lane `addr[1:0]` or half `addr[1]`, then sign-extend (BYTE_S, HALF_S) or zero-extend (BYTE_U, HALF_U). WORD is passed through unchanged.
- Errors:
  - `req_size` in 5–7.
  - Word index ≥ `DEPTH_WORDS` (bits above the index field nonzero).
  - Misalignment (see Configuration).
- RAM contents are not reset; they are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Accept edge T to first edge with `rsp_valid` visible:
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
  - Error: T+1.
- The RAM write occurs at the edge that ends WR.
- Reset asserted in any state: return to IDLE immediately and drop the request.
  - Reset before the WR-ending edge: no write occurs.
  - A store already written remains in RAM.
- `rsp_ready` held high continuously gives back-to-back throughput of one access per 3 cycles (load or word store).
- `req_valid` outside IDLE is ignored. The core must hold the request until accepted.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined: a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, gives an error response. There is no RAM access, and `rsp_rdata` = 0.
- Macro undefined: misaligned low address bits are ignored for the access width. Half uses `addr[1]` only; word uses offset 0. The access completes normally with no error.

## Structure
- Shared package (`Instructions`):
  - The existing `MEM_RW_SIZE` enum is the size encoding.
  - Add typedef `dmem_state_t` for IDLE/RD/WR/RESP.
  - Add constant `MEM_SIZE_W` = 3.
- One combinational sub-module, `dmem_lane_unit`, contains:
  - Store merge (word, addr[1:0], wdata, size → new word).
  - Load extract/extend (word, addr[1:0], size → rdata).
- The RAM array is inferred inside `data_mem_ctrl`.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10:
  - Store response has `rsp_valid` at T+2 with err = 0.
  - Load returns 0xDEADBEEF at T+2.
- After the above, byte store 0xAA to 0x12, then loads from 0x12 and 0x10:
  - BYTE_S at 0x12 → 0xFFFFFFAA.
  - BYTE_U at 0x12 → 0x000000AA.
  - WORD at 0x10 → 0xDEAABEEF.
  - The store response arrives at T+3.
- HALF_S store 0x8001 to 0x16, then loads:
  - HALF_S at 0x16 → 0xFFFF8001.
  - HALF_U at 0x16 → 0x00008001.
- Error cases:
  - Load with `req_size` = 6 → err = 1, rdata = 0, response at T+1.
  - Word load at byte address 4*`DEPTH_WORDS` → err = 1.
- Misaligned word store 0x11223344 to 0x21:
  - With `DMEM_MISALIGN_CHECK_EN`: err = 1, and a word load from 0x20 still returns its prior value.
  - Without the macro: a word load from 0x20 returns 0x11223344.
- Hold `rsp_ready` = 0 for 5 cycles, then assert reset for one cycle in the middle of a sub-word store's RD state:
  - `rsp_valid` and data stay stable while stalled.
  - Reset gives `req_ready` = 1 and `rsp_valid` = 0, and the target word is unchanged.
